// File: rtl/arith_pipe_unit.sv
// ---------------------------------------------------------------------------
// arith_pipe_unit
//   Single-issue arithmetic unit with valid/ready handshakes on both sides.
//   Add and subtract complete in one ALU cycle; unsigned multiply runs as an
//   iterative shift-add over WIDTH cycles (one multiplier bit per cycle,
//   LSB first). Only one operation is in flight at a time.
//
// Ports
//   clk        sole clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   high only while IDLE; request accepted on in_valid && in_ready
//   op         00 add, 01 subtract, 10 unsigned multiply, 11 illegal
//   a, b       unsigned operands (WIDTH bits)
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   result     registered 2*WIDTH-bit result, held until overwritten
//   err        result belongs to an illegal op, qualified by out_valid
//   busy       high in any state other than IDLE
// ---------------------------------------------------------------------------
module arith_pipe_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 err,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ALU  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [1:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;        // also serves as the shifting multiplier
   logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifted left each MUL cycle
   logic [2*WIDTH-1:0]   r_acc;      // partial product, never exposed on result
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_err;

   logic [2*WIDTH-1:0]   w_a_ext;
   logic [2*WIDTH-1:0]   w_b_ext;
   logic [2*WIDTH-1:0]   w_sum;
   logic [2*WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0]   w_partial;
   logic [2*WIDTH-1:0]   w_acc_sum;
   logic                 w_mul_last;

   // Zero-extend before add/subtract: the sum keeps its carry, and the
   // difference wraps into a full-width two's-complement value when a < b.
   assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
   assign w_b_ext    = {{WIDTH{1'b0}}, r_b};
   assign w_sum      = w_a_ext + w_b_ext;
   assign w_diff     = w_a_ext - w_b_ext;

   assign w_partial  = r_b[0] ? r_mcand : '0;
   assign w_acc_sum  = r_acc + w_partial;
   assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_next = (op == 2'b10) ? S_MUL : S_ALU;
            end
         end
         S_ALU:  w_state_next = S_DONE;
         S_MUL: begin
            if (w_mul_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            // Return to IDLE only; a new request can be taken next cycle.
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      busy      = (r_state != S_IDLE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
                  r_mcand <= {{WIDTH{1'b0}}, a};
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_ALU: begin
               case (r_op)
                  2'b00: begin
                     r_result <= w_sum;
                     r_err    <= 1'b0;
                  end
                  2'b01: begin
                     r_result <= w_diff;
                     r_err    <= 1'b0;
                  end
                  2'b11: begin
                     r_result <= '0;
                     r_err    <= 1'b1;
                  end
                  default: begin
                     r_result <= '0;
                     r_err    <= 1'b0;
                  end
               endcase
            end
            S_MUL: begin
               r_acc   <= w_acc_sum;
               r_mcand <= r_mcand << 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + CW'(1);
               // Publish the product only once the final bit has been added.
               if (w_mul_last) begin
                  r_result <= w_acc_sum;
                  r_err    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = r_result;
   assign err    = r_err;

endmodule

// File: tb/tb_arith_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_arith_pipe_unit
//   Self-checking bench for arith_pipe_unit (WIDTH=32). Directed vectors for
//   the corner cases plus randomized operations compared against a plain
//   arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_arith_pipe_unit;

   localparam int W = 32;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  result;
   logic            err;
   logic            busy;

   int n_tests;
   int n_fail;

   arith_pipe_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [2*W-1:0] got,
                           input logic [2*W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: what the operation means arithmetically.
   function automatic logic [2*W-1:0] model_result(input logic [1:0] o,
                                                   input logic [W-1:0] x,
                                                   input logic [W-1:0] y);
      logic [2*W-1:0] xe;
      logic [2*W-1:0] ye;
      xe = 64'(x);
      ye = 64'(y);
      case (o)
         2'b00:   return xe + ye;
         2'b01:   return xe - ye;
         2'b10:   return xe * ye;
         default: return '0;
      endcase
   endfunction

   // Issue one operation, check latency, held result, and handshake release.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int hold);
      logic [2*W-1:0] exp_res;
      logic [2*W-1:0] seen;
      int             edges;
      int             exp_lat;
      exp_res = model_result(o, x, y);
      exp_lat = (o == 2'b10) ? W + 1 : 2;

      @(negedge clk);
      check_eq("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = 1'b0;
      @(negedge clk);                      // acceptance edge has passed
      edges = 1;
      check_eq("busy_after_accept", 64'(busy), 64'd1);
      // Scramble inputs while busy; out_ready toggles are ignored until DONE.
      while (!out_valid && edges < 200) begin
         in_valid  = 1'($urandom);
         op        = 2'($urandom);
         a         = $urandom;
         b         = $urandom;
         out_ready = 1'($urandom);
         @(negedge clk);
         edges++;
      end
      out_ready = 1'b0;
      check_eq("latency", 64'(edges), 64'(exp_lat));
      check_eq("result", result, exp_res);
      check_eq("err", 64'(err), (o == 2'b11) ? 64'd1 : 64'd0);
      seen = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_result", result, seen);
         check_eq("hold_out_valid", 64'(out_valid), 64'd1);
         check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);                      // output handshake edge has passed
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq("out_valid_drop", 64'(out_valid), 64'd0);
      check_eq("in_ready_rise", 64'(in_ready), 64'd1);
      check_eq("idle_result_held", result, seen);
      $display("[TB] op=%0d a=%h b=%h -> result=%h err=%0b lat=%0d",
               o, x, y, result, err, edges);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check_eq({tag, "_busy"},      64'(busy),      64'd0);
      check_eq({tag, "_result"},    result,         64'd0);
      check_eq({tag, "_err"},       64'(err),       64'd0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'b00;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Directed corner cases
      run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op(2'b01, 32'd5, 32'd7, 1);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 2);
      run_op(2'b10, 32'd3, 32'd4, 10);
      run_op(2'b10, 32'd0, 32'hDEAD_BEEF, 0);
      run_op(2'b01, 32'd0, 32'hFFFF_FFFF, 0);

      // Reset in the middle of a multiply
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b10;
      a        = 32'd1000;
      b        = 32'd77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("mul_rst");
      run_op(2'b00, 32'd2, 32'd3, 0);

      // Reset while in DONE with out_ready asserted
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b00;
      a        = 32'd40;
      b        = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("done_before_rst", 64'(out_valid), 64'd1);
      rst       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b0;
      check_reset_state("done_rst");

      // Randomized operations
      for (int t = 0; t < 40; t++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         if (t % 4 == 0) ra = 32'($urandom_range(0, 15));
         run_op(ro, ra, rb, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arith_pipe_unit.md
ARITH_PIPE_UNIT -- requirements
Module: arith_pipe_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1, operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 2, operation: 00 add, 01 subtract, 10 unsigned multiply, 11 illegal.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, unsigned operands.
REQ-008 The block SHALL have port out_valid, output, 1, result valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port result, output, 2*WIDTH, registered result.
REQ-011 The block SHALL have port err, output, 1, result is for an illegal op; qualified by out_valid.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ALU, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready at a rising edge, latching op, a, b into internal registers.
REQ-015 On acceptance the FSM SHALL go to MUL if op=10, else to ALU.
REQ-016 ALU SHALL last one cycle, write result, err and go to DONE; out_valid SHALL be high the cycle after ALU (2 edges after acceptance).
REQ-017 Add: result SHALL be {zeros, carry, a+b}, i.e. the exact (WIDTH+1)-bit sum zero-extended to 2*WIDTH.
REQ-018 Subtract: result SHALL be a-b as a 2*WIDTH-bit two's-complement value (operands zero-extended before subtraction); a<b gives a negative (sign-extended) value.
REQ-019 Illegal op 11: result SHALL be 0 and err SHALL be 1; err SHALL be 0 for all other ops.
REQ-020 MUL SHALL be an iterative shift-add multiplier, one multiplier bit per cycle, LSB first, exactly WIDTH cycles in MUL, then DONE; out_valid high WIDTH+1 edges after acceptance.
REQ-021 Multiply result SHALL be the exact unsigned 2*WIDTH-bit product a*b.
REQ-022 An internal iteration counter of width ceil(log2(WIDTH+1)) SHALL count MUL cycles and SHALL be cleared on entry to MUL.
REQ-023 In DONE, out_valid SHALL be 1 and result/err SHALL be held stable until out_valid && out_ready at a rising edge.
REQ-024 On output handshake the FSM SHALL return to IDLE; out_valid SHALL drop and in_ready rise on the following cycle (no accept in the same cycle as the output handshake).
REQ-025 Changes on a, b, op, in_valid while not in IDLE SHALL have no effect on the operation in flight.
REQ-026 result SHALL hold the last delivered value in IDLE until overwritten by the next ALU or MUL completion; intermediate MUL partial products SHALL NOT appear on result.
REQ-027 out_ready asserted while out_valid=0 SHALL be ignored.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, result=0, err=0, out_valid=0, busy=0, counter=0, in_ready=1 after that edge.
REQ-029 rst SHALL take priority over any handshake in the same cycle, including mid-MUL and in DONE; the in-flight operation SHALL be discarded with no out_valid pulse.
REQ-030 No register SHALL hold X or Z after reset.

Verification
REQ-031 WIDTH=32, op=00, a=FFFFFFFF, b=00000001, out_ready=1 -> out_valid 2 edges after accept, result=0000000100000000, err=0.
REQ-032 WIDTH=32, op=01, a=5, b=7 -> result=FFFFFFFFFFFFFFFE, err=0.
REQ-033 WIDTH=32, op=10, a=FFFFFFFF, b=FFFFFFFF -> out_valid exactly 33 edges after accept, result=FFFFFFFE00000001.
REQ-034 op=11, any a/b -> result=0, err=1, out_valid 2 edges after accept.
REQ-035 op=10, a=3, b=4, out_ready=0 for 10 cycles in DONE, then 1 -> result=12 stable throughout, in_ready low until the cycle after handshake.
REQ-036 op=10 accepted, rst=1 at MUL cycle 5 -> next cycle IDLE, out_valid=0, result=0, in_ready=1; a following add 2+3 returns 5.
